// File: rtl/stopwatch_counter.sv
// Elapsed-time datapath for the stopwatch: 10 ms prescaler feeding a four-digit
// BCD cascade (SS.hh, 00.00-99.99) with registered tick/wrap pulses.
module stopwatch_counter #(
    parameter int unsigned TICK_DIV = 1000000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_regs,
    input  logic       count_enabled,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] hund_tens,
    output logic [3:0] hund_ones,
    output logic       tick,
    output logic       wrapped
);

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] PRE_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] prescaler_q, prescaler_d;
    logic [3:0]       hund_ones_q, hund_ones_d;
    logic [3:0]       hund_tens_q, hund_tens_d;
    logic [3:0]       sec_ones_q,  sec_ones_d;
    logic [3:0]       sec_tens_q,  sec_tens_d;
    logic             tick_q,      tick_d;
    logic             wrapped_q,   wrapped_d;

    logic [3:0] ho_inc, ht_inc, so_inc, st_inc;
    logic       c_ho, c_ht, c_so, c_st;

    // One decimal digit step; any value >= 9 rolls to 0 so a corrupted digit self-heals.
    function automatic logic [4:0] bcd_step(input logic [3:0] d, input logic cin);
        if (!cin) begin
            return {1'b0, d};
        end
        if (d >= 4'd9) begin
            return {1'b1, 4'd0};
        end
        return {1'b0, d + 4'd1};
    endfunction

    always_comb begin : digit_chain
        {c_ho, ho_inc} = bcd_step(hund_ones_q, 1'b1);
        {c_ht, ht_inc} = bcd_step(hund_tens_q, c_ho);
        {c_so, so_inc} = bcd_step(sec_ones_q,  c_ht);
        {c_st, st_inc} = bcd_step(sec_tens_q,  c_so);
    end

    always_comb begin : next_state
        prescaler_d = prescaler_q;
        hund_ones_d = hund_ones_q;
        hund_tens_d = hund_tens_q;
        sec_ones_d  = sec_ones_q;
        sec_tens_d  = sec_tens_q;
        tick_d      = 1'b0;
        wrapped_d   = 1'b0;

        if (init_regs) begin
            prescaler_d = '0;
            hund_ones_d = '0;
            hund_tens_d = '0;
            sec_ones_d  = '0;
            sec_tens_d  = '0;
        end else if (count_enabled) begin
            if (prescaler_q >= PRE_LAST) begin
                prescaler_d = '0;
                tick_d      = 1'b1;
                wrapped_d   = c_st;
                hund_ones_d = ho_inc;
                hund_tens_d = ht_inc;
                sec_ones_d  = so_inc;
                sec_tens_d  = st_inc;
            end else begin
                prescaler_d = prescaler_q + PRE_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q <= '0;
            hund_ones_q <= '0;
            hund_tens_q <= '0;
            sec_ones_q  <= '0;
            sec_tens_q  <= '0;
            tick_q      <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            hund_ones_q <= hund_ones_d;
            hund_tens_q <= hund_tens_d;
            sec_ones_q  <= sec_ones_d;
            sec_tens_q  <= sec_tens_d;
            tick_q      <= tick_d;
            wrapped_q   <= wrapped_d;
        end
    end

    assign sec_tens  = sec_tens_q;
    assign sec_ones  = sec_ones_q;
    assign hund_tens = hund_tens_q;
    assign hund_ones = hund_ones_q;
    assign tick      = tick_q;
    assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter with TICK_DIV = 4.
module tb_stopwatch_counter;

    logic       clk;
    logic       reset;
    logic       init_regs;
    logic       count_enabled;
    logic [3:0] sec_tens, sec_ones, hund_tens, hund_ones;
    logic       tick;
    logic       wrapped;
    logic [15:0] disp;

    int n_tests;
    int n_fail;
    int t_cnt;
    int w_cnt;
    int bad_pos;

    stopwatch_counter #(
        .TICK_DIV(4),
        .CNT_W   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init_regs    (init_regs),
        .count_enabled(count_enabled),
        .sec_tens     (sec_tens),
        .sec_ones     (sec_ones),
        .hund_tens    (hund_tens),
        .hund_ones    (hund_ones),
        .tick         (tick),
        .wrapped      (wrapped)
    );

    assign disp = {sec_tens, sec_ones, hund_tens, hund_ones};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, output int ticks, output int wraps);
        ticks = 0;
        wraps = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (tick)    ticks++;
            if (wrapped) wraps++;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1; init_regs = 1'b0; count_enabled = 1'b0;

        // 1: reset then idle
        step(); step();
        check("rst_disp", disp, 16'h0000);
        check("rst_tick", tick, 0);
        check("rst_wrap", wrapped, 0);
        reset = 1'b0;
        run(10, t_cnt, w_cnt);
        check("idle_disp", disp, 16'h0000);
        check("idle_ticks", t_cnt, 0);
        check("idle_wraps", w_cnt, 0);

        // 2: 40 enabled cycles -> ticks on every 4th edge
        count_enabled = 1'b1;
        t_cnt = 0;
        bad_pos = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (tick) t_cnt++;
            if (tick != (i % 4 == 0)) bad_pos++;
            if (i == 39) check("t2_before_carry", disp, 16'h0009);
        end
        check("t2_ticks", t_cnt, 10);
        check("t2_tick_pos", bad_pos, 0);
        check("t2_disp", disp, 16'h0010);

        // 3: pause keeps partial prescaler count
        run(2, t_cnt, w_cnt);
        check("t3_pre_ticks", t_cnt, 0);
        count_enabled = 1'b0;
        run(7, t_cnt, w_cnt);
        check("t3_pause_ticks", t_cnt, 0);
        check("t3_pause_disp", disp, 16'h0010);
        count_enabled = 1'b1;
        step();
        check("t3_resume1_tick", tick, 0);
        check("t3_resume1_disp", disp, 16'h0010);
        step();
        check("t3_resume2_tick", tick, 1);
        check("t3_resume2_disp", disp, 16'h0011);
        count_enabled = 1'b0;

        // 4: 09.99 -> 10.00
        init_regs = 1'b1;
        step();
        init_regs = 1'b0;
        check("t4_init_disp", disp, 16'h0000);
        count_enabled = 1'b1;
        run(999 * 4, t_cnt, w_cnt);
        check("t4_disp_0999", disp, 16'h0999);
        check("t4_ticks", t_cnt, 999);
        check("t4_wraps", w_cnt, 0);
        run(3, t_cnt, w_cnt);
        check("t4_hold_disp", disp, 16'h0999);
        check("t4_hold_tick", tick, 0);
        step();
        check("t4_carry_disp", disp, 16'h1000);
        check("t4_carry_tick", tick, 1);
        check("t4_carry_wrap", wrapped, 0);

        // 5: 99.99 -> 00.00 wrap
        run(8999 * 4, t_cnt, w_cnt);
        check("t5_disp_9999", disp, 16'h9999);
        check("t5_ticks", t_cnt, 8999);
        check("t5_early_wraps", w_cnt, 0);
        run(3, t_cnt, w_cnt);
        step();
        check("t5_wrap_disp", disp, 16'h0000);
        check("t5_wrap_tick", tick, 1);
        check("t5_wrap_wrap", wrapped, 1);
        step();
        check("t5_after_tick", tick, 0);
        check("t5_after_wrap", wrapped, 0);
        check("t5_after_disp", disp, 16'h0000);
        run(2, t_cnt, w_cnt);
        step();
        check("t5_resume_disp", disp, 16'h0001);
        check("t5_resume_tick", tick, 1);

        // 6a: init_regs with count_enabled from 05.37, prescaler at 2
        count_enabled = 1'b0;
        init_regs = 1'b1;
        step();
        init_regs = 1'b0;
        count_enabled = 1'b1;
        run(537 * 4 + 2, t_cnt, w_cnt);
        check("t6_disp_0537", disp, 16'h0537);
        init_regs = 1'b1;
        step();
        check("t6_init_disp", disp, 16'h0000);
        check("t6_init_tick", tick, 0);
        init_regs = 1'b0;
        run(3, t_cnt, w_cnt);
        check("t6_init_pre_cleared", t_cnt, 0);
        step();
        check("t6_init_first_tick", tick, 1);
        check("t6_init_first_disp", disp, 16'h0001);
        // init on the edge that would have ticked
        run(3, t_cnt, w_cnt);
        init_regs = 1'b1;
        step();
        check("t6_init_tickedge_tick", tick, 0);
        check("t6_init_tickedge_disp", disp, 16'h0000);
        init_regs = 1'b0;

        // 6b: reset with count_enabled from 12.34
        run(1234 * 4, t_cnt, w_cnt);
        check("t6_disp_1234", disp, 16'h1234);
        reset = 1'b1;
        step();
        check("t6_rst_disp", disp, 16'h0000);
        check("t6_rst_tick", tick, 0);
        reset = 1'b0;
        run(3, t_cnt, w_cnt);
        check("t6_rst_pre_cleared", t_cnt, 0);
        step();
        check("t6_rst_first_tick", tick, 1);
        check("t6_rst_first_disp", disp, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
